// File: rtl/nios2_qsys_0_jtag_debug_host.sv
// Initiator end of the Nios II virtual-JTAG debug link: turns one clk-domain command into an
// IR write plus a DR shift on the vji_* signals and returns the captured tdo word and ir_out.
module nios2_qsys_0_jtag_debug_host #(
    parameter int unsigned TCK_HALF   = 2,
    parameter int unsigned DR_WIDTH   = 38,
    parameter int unsigned RTI_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_ir,
    input  logic [DR_WIDTH-1:0] i_cmd_data,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DR_WIDTH-1:0] o_rsp_data,
    output logic [1:0]          o_rsp_ir_out,
    output logic                o_busy,
    output logic                o_vji_tck,
    output logic                o_vji_tdi,
    input  logic                i_vji_tdo,
    output logic [1:0]          o_vji_ir_in,
    input  logic [1:0]          i_vji_ir_out,
    output logic                o_vji_uir,
    output logic                o_vji_cdr,
    output logic                o_vji_sdr,
    output logic                o_vji_udr,
    output logic                o_vji_rti
);

    localparam int unsigned Period = 2 * TCK_HALF;
    localparam int unsigned CntW   = $clog2(Period);
    localparam int unsigned PerMax = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int unsigned PerW   = $clog2(PerMax + 1);

    localparam logic [CntW-1:0] CntRise   = CntW'(TCK_HALF - 1);
    localparam logic [CntW-1:0] CntHigh   = CntW'(TCK_HALF);
    localparam logic [CntW-1:0] CntLast   = CntW'(Period - 1);
    localparam logic [PerW-1:0] ShiftLast = PerW'(DR_WIDTH - 1);
    localparam logic [PerW-1:0] RtiLast   = PerW'(RTI_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StShift,
        StUdr,
        StRti,
        StResp
    } state_e;

    state_e               r_state;
    state_e               w_state_d;
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      w_cnt_d;
    logic [PerW-1:0]      r_per;
    logic [PerW-1:0]      w_per_d;
    logic [DR_WIDTH-1:0]  r_shreg;
    logic [DR_WIDTH-1:0]  r_capture;
    logic [1:0]           r_ir;
    logic [1:0]           r_rsp_ir;
    logic                 r_cmd_ready;

    logic w_tck_state;
    logic w_per_end;
    logic w_rise;
    logic w_accept;

    assign w_tck_state = (r_state == StUir) || (r_state == StCdr) || (r_state == StShift) ||
                         (r_state == StUdr) || (r_state == StRti);
    assign w_per_end   = (r_cnt == CntLast);
    // tck goes high after this edge, so this is where tdo/ir_out are sampled
    assign w_rise      = w_tck_state && (r_cnt == CntRise);
    assign w_accept    = i_cmd_valid && r_cmd_ready;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StUir;
            StUir:   if (w_per_end) w_state_d = StCdr;
            StCdr:   if (w_per_end) w_state_d = StShift;
            StShift: if (w_per_end && (r_per == ShiftLast)) w_state_d = StUdr;
            StUdr:   if (w_per_end) w_state_d = StRti;
            StRti:   if (w_per_end && (r_per == RtiLast)) w_state_d = StResp;
            StResp:  if (i_rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Phase and period counters restart on every state entry.
    always_comb begin
        w_cnt_d = '0;
        w_per_d = '0;
        if (w_tck_state && (w_state_d == r_state)) begin
            w_cnt_d = w_per_end ? '0 : r_cnt + CntW'(1);
            w_per_d = w_per_end ? r_per + PerW'(1) : r_per;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_per       <= '0;
            r_shreg     <= '0;
            r_capture   <= '0;
            r_ir        <= '0;
            r_rsp_ir    <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_per       <= w_per_d;
            r_cmd_ready <= (w_state_d == StIdle);
            if ((r_state == StIdle) && w_accept) begin
                r_ir    <= i_cmd_ir;
                r_shreg <= i_cmd_data;
            end
            if ((r_state == StShift) && w_rise) begin
                r_capture <= {i_vji_tdo, r_capture[DR_WIDTH-1:1]};
                r_shreg   <= r_shreg >> 1;
            end
            if ((r_state == StUdr) && w_rise) begin
                r_rsp_ir <= i_vji_ir_out;
            end
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_rsp_valid  = (r_state == StResp);
    assign o_rsp_data   = r_capture;
    assign o_rsp_ir_out = r_rsp_ir;
    assign o_busy       = (r_state != StIdle);
    assign o_vji_tck    = w_tck_state && (r_cnt >= CntHigh);
    assign o_vji_tdi    = (r_state == StShift) && r_shreg[0];
    assign o_vji_ir_in  = r_ir;
    assign o_vji_uir    = (r_state == StUir);
    assign o_vji_cdr    = (r_state == StCdr);
    assign o_vji_sdr    = (r_state == StShift);
    assign o_vji_udr    = (r_state == StUdr);
    assign o_vji_rti    = (r_state == StRti);

endmodule
